// File: rtl/uart_pkg.sv
// Shared types and decode helpers for the UART receive framer.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam logic [1:0] PARITY_EVEN  = 2'd0;
  localparam logic [1:0] PARITY_ODD   = 2'd1;
  localparam logic [1:0] PARITY_MARK  = 2'd2;
  localparam logic [1:0] PARITY_SPACE = 2'd3;

  function automatic logic [3:0] decode_data_bits(input logic [1:0] code);
    return 4'd7 + {2'b00, code};
  endfunction

  function automatic logic [1:0] decode_stop_bits(input logic code);
    return code ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// Prescaler plus oversampling counter; a sync clear realigns both to a start edge.
module uart_rx_baud_gen (
  input  logic        i_clk,
  input  logic        i_srst,
  input  logic        i_clr,
  input  logic [11:0] i_clkdiv,
  input  logic [3:0]  i_oversampling,
  output logic        o_sample_tick,
  output logic        o_mid_tick,
  output logic        o_bit_end,
  output logic [3:0]  o_samp_idx
);
  logic [11:0] r_presc;
  logic [3:0]  r_samp;
  logic [3:0]  w_mid;

  assign w_mid         = i_oversampling >> 1;
  assign o_sample_tick = (r_presc == i_clkdiv);
  assign o_mid_tick    = o_sample_tick && (r_samp == w_mid);
  assign o_bit_end     = o_sample_tick && (r_samp == i_oversampling);
  assign o_samp_idx    = r_samp;

  always_ff @(posedge i_clk) begin
    if (i_srst || i_clr) begin
      r_presc <= '0;
      r_samp  <= '0;
    end else if (o_sample_tick) begin
      r_presc <= '0;
      r_samp  <= (r_samp == i_oversampling) ? 4'd0 : r_samp + 4'd1;
    end else begin
      r_presc <= r_presc + 12'd1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_decoder.sv
// UART receive framer: sync, start detect, field recovery, FIFO write and status pulses.
// Optional build macro UART_RX_NOISE_FILTER_EN enables 2-of-3 majority bit sampling.
module uart_rx_frame_decoder
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        pe_clk,
  input  logic        pe_rst,
  input  logic        uart_rx,
  input  logic        rx_enable,
  input  logic        logic_clr,
  input  logic [11:0] r_clkdiv,
  input  logic [3:0]  r_oversampling,
  input  logic [1:0]  r_data_bit,
  input  logic        r_parity_en,
  input  logic [1:0]  r_parity,
  input  logic        r_stop_bit,
  input  logic        r_error_ignore,
  output logic        fifo_we,
  output logic [9:0]  fifo_data,
  input  logic [4:0]  fifo_num,
  output logic        rx_busy,
  output logic        int_status_rx_stop_detect,
  output logic        int_status_rx_parity_error,
  output logic        int_status_rx_stop_error,
  output logic        int_status_rx_noise_detect,
  output logic        int_status_rx_overflow
);
  localparam logic [4:0] FIFO_FULL = 5'(FIFO_DEPTH);

  rx_state_e   r_state;
  logic        r_sync1, r_sync2, r_line_prev;
  logic [11:0] r_cfg_clkdiv;
  logic [3:0]  r_cfg_os;
  logic [3:0]  r_cfg_nbits;
  logic [1:0]  r_cfg_nstop;
  logic        r_cfg_par_en;
  logic [1:0]  r_cfg_parity;
  logic        r_cfg_ignore;
  logic [9:0]  r_shift;
  logic [3:0]  r_bit_cnt;
  logic        r_par, r_perr, r_serr, r_noise;
  logic        r_fifo_we;
  logic [9:0]  r_fifo_data;
  logic        r_stat_stop, r_stat_perr, r_stat_serr, r_stat_noise, r_stat_ovf;

  logic        w_fall, w_start;
  logic        w_sample_tick, w_mid_tick, w_bit_end;
  logic [3:0]  w_samp_idx;
  logic        w_decide, w_bit, w_disagree;
  logic        w_par_exp, w_serr_final, w_noise_final, w_last_stop;

  // The synchronizer is deliberately left alone by the soft clear.
  always_ff @(posedge pe_clk) begin
    if (pe_rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_line_prev <= 1'b1;
    end else begin
      r_sync1     <= uart_rx;
      r_sync2     <= r_sync1;
      r_line_prev <= r_sync2;
    end
  end

  assign w_fall  = r_line_prev & ~r_sync2;
  assign w_start = (r_state == ST_IDLE) && rx_enable && w_fall;

  uart_rx_baud_gen u_baud (
    .i_clk          (pe_clk),
    .i_srst         (pe_rst),
    .i_clr          (logic_clr | w_start),
    .i_clkdiv       (r_cfg_clkdiv),
    .i_oversampling (r_cfg_os),
    .o_sample_tick  (w_sample_tick),
    .o_mid_tick     (w_mid_tick),
    .o_bit_end      (w_bit_end),
    .o_samp_idx     (w_samp_idx)
  );

`ifdef UART_RX_NOISE_FILTER_EN
  logic       r_s_lo, r_s_mid;
  logic [3:0] w_mid;
  assign w_mid = r_cfg_os >> 1;

  always_ff @(posedge pe_clk) begin
    if (pe_rst || logic_clr) begin
      r_s_lo  <= 1'b1;
      r_s_mid <= 1'b1;
    end else begin
      if (w_sample_tick && (w_samp_idx == w_mid - 4'd1)) r_s_lo <= r_sync2;
      if (w_mid_tick) r_s_mid <= r_sync2;
    end
  end

  // The decision is taken on the third tap, so the live line is the mid+1 sample.
  assign w_decide   = w_sample_tick && (w_samp_idx == w_mid + 4'd1);
  assign w_bit      = (r_s_lo & r_s_mid) | (r_s_lo & r_sync2) | (r_s_mid & r_sync2);
  assign w_disagree = !((r_s_lo == r_s_mid) && (r_s_mid == r_sync2));
`else
  logic w_unused_taps;
  assign w_unused_taps = ^{w_sample_tick, w_samp_idx};
  assign w_decide      = w_mid_tick;
  assign w_bit         = r_sync2;
  assign w_disagree    = 1'b0;
`endif

  always_comb begin
    case (r_cfg_parity)
      PARITY_EVEN: w_par_exp = r_par;
      PARITY_ODD:  w_par_exp = ~r_par;
      PARITY_MARK: w_par_exp = 1'b1;
      default:     w_par_exp = 1'b0;
    endcase
  end

  assign w_serr_final  = r_serr | ~w_bit;
  assign w_noise_final = r_noise | w_disagree;
  assign w_last_stop   = (r_bit_cnt == {2'b00, r_cfg_nstop} - 4'd1);

  always_ff @(posedge pe_clk) begin
    if (pe_rst || logic_clr) begin
      r_state      <= ST_IDLE;
      r_cfg_clkdiv <= '0;
      r_cfg_os     <= '0;
      r_cfg_nbits  <= '0;
      r_cfg_nstop  <= '0;
      r_cfg_par_en <= 1'b0;
      r_cfg_parity <= '0;
      r_cfg_ignore <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_perr       <= 1'b0;
      r_serr       <= 1'b0;
      r_noise      <= 1'b0;
      r_fifo_we    <= 1'b0;
      r_fifo_data  <= '0;
      r_stat_stop  <= 1'b0;
      r_stat_perr  <= 1'b0;
      r_stat_serr  <= 1'b0;
      r_stat_noise <= 1'b0;
      r_stat_ovf   <= 1'b0;
    end else begin
      r_fifo_we    <= 1'b0;
      r_stat_stop  <= 1'b0;
      r_stat_perr  <= 1'b0;
      r_stat_serr  <= 1'b0;
      r_stat_noise <= 1'b0;
      r_stat_ovf   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cfg_clkdiv <= r_clkdiv;
            r_cfg_os     <= r_oversampling;
            r_cfg_nbits  <= decode_data_bits(r_data_bit);
            r_cfg_nstop  <= decode_stop_bits(r_stop_bit);
            r_cfg_par_en <= r_parity_en;
            r_cfg_parity <= r_parity;
            r_cfg_ignore <= r_error_ignore;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_par        <= 1'b0;
            r_perr       <= 1'b0;
            r_serr       <= 1'b0;
            r_noise      <= 1'b0;
            r_state      <= ST_START;
          end
        end
        ST_START: begin
          if (w_decide && w_bit) begin
            r_stat_noise <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            if (w_decide) r_noise <= w_noise_final;
            if (w_bit_end) begin
              r_bit_cnt <= '0;
              r_state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_decide) begin
            r_shift[r_bit_cnt] <= w_bit;
            r_par              <= r_par ^ w_bit;
            r_noise            <= w_noise_final;
          end
          if (w_bit_end) begin
            if (r_bit_cnt == r_cfg_nbits - 4'd1) begin
              r_bit_cnt <= '0;
              r_state   <= r_cfg_par_en ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_decide) begin
            if (w_bit != w_par_exp) r_perr <= 1'b1;
            r_noise <= w_noise_final;
          end
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_decide && w_last_stop) begin
            r_stat_stop  <= 1'b1;
            r_stat_perr  <= r_perr;
            r_stat_serr  <= w_serr_final;
            r_stat_noise <= w_noise_final;
            if (fifo_num == FIFO_FULL) begin
              r_stat_ovf <= 1'b1;
            end else if (!(r_perr || w_serr_final) || r_cfg_ignore) begin
              r_fifo_we   <= 1'b1;
              r_fifo_data <= r_shift;
            end
            // A zero character with a missing stop bit is a line break.
            r_state <= ((r_shift == '0) && w_serr_final) ? ST_BREAK : ST_IDLE;
          end else begin
            if (w_decide) begin
              r_serr  <= w_serr_final;
              r_noise <= w_noise_final;
            end
            if (w_bit_end) r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        ST_BREAK: begin
          if (r_sync2) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_we                    = r_fifo_we;
  assign fifo_data                  = r_fifo_data;
  assign rx_busy                    = (r_state != ST_IDLE);
  assign int_status_rx_stop_detect  = r_stat_stop;
  assign int_status_rx_parity_error = r_stat_perr;
  assign int_status_rx_stop_error   = r_stat_serr;
  assign int_status_rx_noise_detect = r_stat_noise;
  assign int_status_rx_overflow     = r_stat_ovf;

endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Directed bench for the UART receive framer with an event scoreboard.
module tb_uart_rx_frame_decoder;
  localparam int BIT = 64;

  logic        pe_clk, pe_rst, uart_rx, rx_enable, logic_clr;
  logic [11:0] r_clkdiv;
  logic [3:0]  r_oversampling;
  logic [1:0]  r_data_bit, r_parity;
  logic        r_parity_en, r_stop_bit, r_error_ignore;
  logic        fifo_we, rx_busy;
  logic [9:0]  fifo_data;
  logic [4:0]  fifo_num;
  logic        st_stop, st_perr, st_serr, st_noise, st_ovf;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       we;
    logic [9:0] data;
    logic       stop;
    logic       perr;
    logic       serr;
    logic       noise;
    logic       ovf;
  } ev_t;

  ev_t        exp_q[$];
  logic [9:0] model_data = '0;

  uart_rx_frame_decoder #(.FIFO_DEPTH(16)) dut (
    .pe_clk                     (pe_clk),
    .pe_rst                     (pe_rst),
    .uart_rx                    (uart_rx),
    .rx_enable                  (rx_enable),
    .logic_clr                  (logic_clr),
    .r_clkdiv                   (r_clkdiv),
    .r_oversampling             (r_oversampling),
    .r_data_bit                 (r_data_bit),
    .r_parity_en                (r_parity_en),
    .r_parity                   (r_parity),
    .r_stop_bit                 (r_stop_bit),
    .r_error_ignore             (r_error_ignore),
    .fifo_we                    (fifo_we),
    .fifo_data                  (fifo_data),
    .fifo_num                   (fifo_num),
    .rx_busy                    (rx_busy),
    .int_status_rx_stop_detect  (st_stop),
    .int_status_rx_parity_error (st_perr),
    .int_status_rx_stop_error   (st_serr),
    .int_status_rx_noise_detect (st_noise),
    .int_status_rx_overflow     (st_ovf)
  );

  initial pe_clk = 1'b0;
  always #5 pe_clk = ~pe_clk;

  function automatic void expect_ev(input logic we, input logic [9:0] d, input logic stop,
                                    input logic perr, input logic serr, input logic noise,
                                    input logic ovf);
    ev_t e;
    e.we    = we;
    e.data  = we ? d : model_data;
    e.stop  = stop;
    e.perr  = perr;
    e.serr  = serr;
    e.noise = noise;
    e.ovf   = ovf;
    if (we) model_data = d;
    exp_q.push_back(e);
  endfunction

  // Monitor: any write strobe or status pulse is one transaction to score.
  always @(negedge pe_clk) begin
    if (!pe_rst && (fifo_we | st_stop | st_perr | st_serr | st_noise | st_ovf)) begin
      ev_t act, e;
      act = {fifo_we, fifo_data, st_stop, st_perr, st_serr, st_noise, st_ovf};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event got=%h required=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL event got=%h required=%h", act, e);
        end else begin
          $display("event we=%0b data=%h stop=%0b perr=%0b serr=%0b noise=%0b ovf=%0b",
                   act.we, act.data, act.stop, act.perr, act.serr, act.noise, act.ovf);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end else begin
      $display("check %s = %h", name, act);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge pe_clk);
  endtask

  task automatic send_frame(input logic [9:0] d, input int nbits, input bit par_en,
                            input bit par, input int nstop);
    uart_rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < nbits; i++) begin
      uart_rx = d[i];
      wait_clk(BIT);
    end
    if (par_en) begin
      uart_rx = par;
      wait_clk(BIT);
    end
    uart_rx = 1'b1;
    wait_clk(BIT * nstop);
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic pen, input logic [1:0] par,
                         input logic sb, input logic ign);
    r_data_bit     = db;
    r_parity_en    = pen;
    r_parity       = par;
    r_stop_bit     = sb;
    r_error_ignore = ign;
  endtask

  initial begin
    pe_rst = 1'b1;  uart_rx = 1'b1;  rx_enable = 1'b1;  logic_clr = 1'b0;
    r_clkdiv = 12'd3;  r_oversampling = 4'd15;  fifo_num = 5'd0;
    set_cfg(2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    wait_clk(5);
    #1;
    check("reset_outputs", {22'd0, fifo_we, fifo_data, rx_busy, st_stop, st_perr, st_serr,
                            st_noise, st_ovf}, 32'd0);
    @(posedge pe_clk);
    pe_rst = 1'b0;
    wait_clk(20);
    #1 check("idle_after_reset", {31'd0, rx_busy}, 32'd0);

    // 8N1 0xA5
    expect_ev(1'b1, 10'h0A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(10'h0A5, 8, 1'b0, 1'b0, 1);
    wait_clk(BIT);

    // 8O1 0x3C: four ones, so the correct odd parity bit is 1; send 0.
    set_cfg(2'd1, 1'b1, 2'd1, 1'b0, 1'b0);
    expect_ev(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(10'h03C, 8, 1'b1, 1'b0, 1);
    wait_clk(BIT);
    set_cfg(2'd1, 1'b1, 2'd1, 1'b0, 1'b1);
    expect_ev(1'b1, 10'h03C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(10'h03C, 8, 1'b1, 1'b0, 1);
    wait_clk(BIT);

    // 10E2 back to back: 0x2AB has six ones (parity 0), 0x155 has five (parity 1).
    set_cfg(2'd3, 1'b1, 2'd0, 1'b1, 1'b0);
    expect_ev(1'b1, 10'h2AB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_ev(1'b1, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(10'h2AB, 10, 1'b1, 1'b0, 2);
    send_frame(10'h155, 10, 1'b1, 1'b1, 2);
    wait_clk(BIT);

    // 10-clock low glitch on an idle line.
    set_cfg(2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    expect_ev(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    uart_rx = 1'b0;
    wait_clk(10);
    uart_rx = 1'b1;
    wait_clk(2 * BIT);
    #1 check("idle_after_glitch", {31'd0, rx_busy}, 32'd0);

    // Full FIFO.
    fifo_num = 5'd16;
    expect_ev(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(10'h055, 8, 1'b0, 1'b0, 1);
    wait_clk(BIT);
    fifo_num = 5'd0;

    // Line held low for three frame times: one stop error, then BREAK.
    expect_ev(1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    uart_rx = 1'b0;
    wait_clk(3 * 10 * BIT);
    #1 check("busy_in_break", {31'd0, rx_busy}, 32'd1);
    uart_rx = 1'b1;
    wait_clk(10);
    #1 check("idle_after_break", {31'd0, rx_busy}, 32'd0);
    wait_clk(12 * BIT);

    // Soft clear during data bit 4 of an 0xFF frame (line stays high after start).
    uart_rx = 1'b0;
    wait_clk(BIT);
    uart_rx = 1'b1;
    wait_clk(4 * BIT + BIT / 2);
    #1 check("busy_before_clr", {31'd0, rx_busy}, 32'd1);
    @(posedge pe_clk);
    logic_clr = 1'b1;
    @(posedge pe_clk);
    logic_clr = 1'b0;
    #1 check("idle_after_clr", {31'd0, rx_busy}, 32'd0);
    wait_clk(6 * BIT);
    expect_ev(1'b1, 10'h081, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(10'h081, 8, 1'b0, 1'b0, 1);
    wait_clk(4 * BIT);
    #1 check("fifo_data_hold", {22'd0, fifo_data}, {22'd0, model_data});

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
